mem_bus_arbiter: RTL and testbench

//  Shares the Processor's single memory bus between two requesters: instruction fetch (F) and

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_timeout.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 114 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state/grant encodings and round-robin pick for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_t;

  // On a tie the requester that did not win last time gets the bus.
  function automatic arb_gnt_t pick_grant(input logic f_req, input logic d_req, input arb_gnt_t last);
    if (f_req && d_req) return (last == GNT_F) ? GNT_D : GNT_F;
    return d_req ? GNT_D : GNT_F;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// rtl/mem_bus_arbiter_timeout.sv - access wait counter that flags expiry after TIMEOUT cycles
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_en && !o_expire)
      r_count <= r_count + 1'b1;
  end

  assign o_expire = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between fetch and load/store requesters
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iFReq,
  input  logic [ADDR_W-1:0] iFAddr,
  output logic [DATA_W-1:0] oFData,
  output logic              oFAck,
  input  logic              iDReq,
  input  logic              iDWrite,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic [DATA_W-1:0] oDData,
  output logic              oDAck,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemRdy,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic              oTimeout
);

  arb_state_t r_state;
  arb_gnt_t   r_gnt;
  logic       r_write;
  arb_gnt_t   w_pick;
  logic       w_expire;
  logic       w_in_access;

  assign w_in_access = (r_state == ST_ACCESS);
  assign w_pick      = pick_grant(iFReq, iDReq, r_gnt);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (iClk),
    .i_rst    (iRst),
    .i_clear  (!w_in_access),
    .i_en     (w_in_access),
    .o_expire (w_expire)
  );

  // r_gnt doubles as lastGrant: it keeps the most recent winner after the access ends.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= GNT_F;
      r_write   <= 1'b0;
      oFData    <= '0;
      oFAck     <= 1'b0;
      oDData    <= '0;
      oDAck     <= 1'b0;
      oMemAddr  <= '0;
      oMemData  <= '0;
      oMemRead  <= 1'b0;
      oMemWrite <= 1'b0;
      oTimeout  <= 1'b0;
    end else begin
      oFAck <= 1'b0;
      oDAck <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iFReq || iDReq) begin
            r_gnt   <= w_pick;
            r_state <= ST_ACCESS;
            if (w_pick == GNT_D) begin
              oMemAddr  <= iDAddr;
              oMemData  <= iDWData;
              r_write   <= iDWrite;
              oMemRead  <= !iDWrite;
              oMemWrite <= iDWrite;
            end else begin
              oMemAddr  <= iFAddr;
              oMemData  <= '0;
              r_write   <= 1'b0;
              oMemRead  <= 1'b1;
              oMemWrite <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (iMemRdy || w_expire) begin
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            r_state   <= ST_ACK;
            if (r_gnt == GNT_D) oDAck <= 1'b1;
            else                oFAck <= 1'b1;
            // Ready wins over a simultaneous expiry; writes leave the returned data untouched.
            if (iMemRdy) begin
              if (!r_write) begin
                if (r_gnt == GNT_D) oDData <= iMemData;
                else                oFData <= iMemData;
              end
            end else begin
              oTimeout <= 1'b1;
              if (r_gnt == GNT_D) oDData <= '0;
              else                oFData <= '0;
            end
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        iClk, iRst;
  logic        iFReq, iDReq, iDWrite, iMemRdy;
  logic [31:0] iFAddr, iDAddr, iDWData, iMemData;
  logic [31:0] oFData, oDData, oMemAddr, oMemData;
  logic        oFAck, oDAck, oMemRead, oMemWrite, oTimeout;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iRst(iRst),
    .iFReq(iFReq), .iFAddr(iFAddr), .oFData(oFData), .oFAck(oFAck),
    .iDReq(iDReq), .iDWrite(iDWrite), .iDAddr(iDAddr), .iDWData(iDWData),
    .oDData(oDData), .oDAck(oDAck),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemData(iMemData), .iMemRdy(iMemRdy),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oTimeout(oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_pass = 0;
  int n_total = 0;

  bit          pf, pd, dwr, last_d, exp_to, gd;
  logic [31:0] fa, da, dw, exp_fd, exp_dd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive_reqs();
    iFReq = pf; iFAddr = fa;
    iDReq = pd; iDAddr = da; iDWrite = dwr; iDWData = dw;
  endtask

  task automatic do_reset();
    iRst = 1'b1; iMemRdy = 1'b0; iMemData = '0;
    pf = 0; pd = 0; drive_reqs();
    step();
    check("rst_fack", {31'b0, oFAck}, 0);
    check("rst_dack", {31'b0, oDAck}, 0);
    check("rst_strobes", {30'b0, oMemRead, oMemWrite}, 0);
    check("rst_addr", oMemAddr, 0);
    check("rst_fdata", oFData, 0);
    check("rst_timeout", {31'b0, oTimeout}, 0);
    step();
    iRst = 1'b0;
    last_d = 0; exp_fd = 0; exp_dd = 0; exp_to = 0;
  endtask

  // One complete access from IDLE: predicts the winner from the pending requests and the
  // previous winner, plays memory with 'waits' stall cycles (>= TIMEOUT means never ready).
  task automatic run_access(input int waits, input logic [31:0] rdata, output bit got_d);
    bit win_d, to, ew;
    int g, n;
    logic [31:0] eaddr;
    win_d = pd && (!pf || !last_d);
    last_d = win_d;
    to = (waits >= TIMEOUT);
    ew = win_d && dwr;
    eaddr = win_d ? da : fa;
    drive_reqs();
    g = 0;
    do begin
      iMemRdy = 1'($urandom % 2);
      iMemData = $urandom;
      step();
      g++;
    end while (!(oMemRead || oMemWrite) && g < 4);
    check("grant_latency", g, 1);
    n = 0;
    while (n < TIMEOUT + 4) begin
      n++;
      check("strobe_rd", {31'b0, oMemRead}, {31'b0, !ew});
      check("strobe_wr", {31'b0, oMemWrite}, {31'b0, ew});
      check("bus_addr", oMemAddr, eaddr);
      if (ew) check("bus_wdata", oMemData, dw);
      iMemRdy = !to && (n == waits + 1);
      iMemData = iMemRdy ? rdata : $urandom;
      step();
      if (oFAck || oDAck) break;
    end
    iMemRdy = 1'($urandom % 2);
    check("access_cycles", n, to ? TIMEOUT : waits + 1);
    if (to) begin
      exp_to = 1;
      if (win_d) exp_dd = 0; else exp_fd = 0;
    end else if (!ew) begin
      if (win_d) exp_dd = rdata; else exp_fd = rdata;
    end
    check("f_ack", {31'b0, oFAck}, {31'b0, !win_d});
    check("d_ack", {31'b0, oDAck}, {31'b0, win_d});
    check("f_data", oFData, exp_fd);
    check("d_data", oDData, exp_dd);
    check("timeout_flag", {31'b0, oTimeout}, {31'b0, exp_to});
    check("ack_strobes", {30'b0, oMemRead, oMemWrite}, 0);
    step();
    check("ack_one_cycle", {30'b0, oFAck, oDAck}, 0);
    if (win_d) pd = 0; else pf = 0;
    drive_reqs();
    got_d = win_d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fa = 0; da = 0; dw = 0; dwr = 0;
    do_reset();

    // Fetch only, memory ready immediately.
    pf = 1; fa = 32'h10;
    run_access(0, 32'hDEADBEEF, gd);
    check("t1_grant_f", {31'b0, gd}, 0);

    // Store.
    pd = 1; da = 32'd23; dwr = 1; dw = 32'hFFFFFFDE;
    run_access(0, 32'h12345678, gd);
    check("t2_grant_d", {31'b0, gd}, 1);

    // Contention held from reset: D,F,D,F.
    do_reset();
    pf = 1; fa = 32'h100; pd = 1; da = 32'h200; dwr = 0; dw = 0;
    for (int i = 0; i < 4; i++) begin
      run_access(0, $urandom, gd);
      check("t3_rr_order", {31'b0, gd}, (i % 2 == 0) ? 1 : 0);
      if (gd) pd = 1; else pf = 1;
    end
    pf = 0; pd = 0; drive_reqs();

    // Wait states.
    pf = 1; fa = 32'h40;
    run_access(5, 32'hA5A5_0001, gd);

    // Timeout on a read, then sticky flag across normal traffic.
    pd = 1; da = 32'h80; dwr = 0;
    run_access(TIMEOUT, 32'hFFFF_FFFF, gd);

    for (int it = 0; it < 40; it++) begin
      if (!pf && ($urandom % 2 == 1)) begin pf = 1; fa = $urandom; end
      if (!pd && (($urandom % 2 == 1) || !pf)) begin
        pd = 1; da = $urandom; dwr = 1'($urandom % 2); dw = $urandom;
      end
      run_access(($urandom % 8 == 0) ? TIMEOUT : int'($urandom % 6), $urandom, gd);
    end
    pf = 0; pd = 0; drive_reqs();
    step();

    // Reset in the middle of an access.
    pf = 1; fa = 32'h77; drive_reqs();
    iMemRdy = 1'b0;
    step();
    check("t6_pre_rd", {31'b0, oMemRead}, 1);
    #2;
    iRst = 1'b1; iMemRdy = 1'b0;
    #1;
    check("t6_async_rd", {31'b0, oMemRead}, 0);
    check("t6_async_wr", {31'b0, oMemWrite}, 0);
    step();
    check("t6_no_ack", {30'b0, oFAck, oDAck}, 0);
    check("t6_no_timeout", {31'b0, oTimeout}, 0);
    pf = 0; drive_reqs();
    step();
    iRst = 1'b0;
    last_d = 0; exp_fd = 0; exp_dd = 0; exp_to = 0;
    step();
    check("t6_idle_ack", {30'b0, oFAck, oDAck}, 0);
    pf = 1; fa = 32'h99;
    run_access(2, 32'hCAFE_F00D, gd);
    check("t6_fresh_grant", {31'b0, gd}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
